// File: rtl/aes_pkg.sv
// Shared definitions for the AES key controller slice.
//   aes_key_ctrl_state_t : controller FSM states
//   AES_KEY_W            : cipher key width in bits
//   DEF_MAX_INFLIGHT     : default pipeline depth (blocks in flight)
//   DEF_EXP_TIMEOUT      : default expansion wait limit in cycles
package aes_pkg;

  localparam int unsigned AES_KEY_W        = 128;
  localparam int unsigned DEF_MAX_INFLIGHT = 11;
  localparam int unsigned DEF_EXP_TIMEOUT  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_READY,
    ST_DRAIN,
    ST_ERROR
  } aes_key_ctrl_state_t;

endpackage

// File: rtl/aes_key_ctrl_if.sv
// Key-write and block-launch handshakes between the HPS / cipher core
// (master) and the key controller (slave).
//   key_wr_valid/key_wr_ready/key_wr_data : new cipher key transfer
//   blk_req/blk_grant                     : block launch request / grant
//   blk_done                              : one block retired
interface aes_key_ctrl_if;
  import aes_pkg::*;

  logic                 key_wr_valid;
  logic                 key_wr_ready;
  logic [AES_KEY_W-1:0] key_wr_data;
  logic                 blk_req;
  logic                 blk_grant;
  logic                 blk_done;

  modport master (
    output key_wr_valid, key_wr_data, blk_req, blk_done,
    input  key_wr_ready, blk_grant
  );

  modport slave (
    input  key_wr_valid, key_wr_data, blk_req, blk_done,
    output key_wr_ready, blk_grant
  );

endinterface

// File: rtl/aes_inflight_cnt.sv
// Saturating up/down count of blocks in the cipher pipeline.
//   clk, reset : clock, synchronous active-low reset
//   inc        : a block was granted this cycle
//   dec        : a block retired this cycle
//   count      : registered count
//   count_next : value count takes at the next edge
//   full       : count has reached MAX_INFLIGHT
module aes_inflight_cnt
  import aes_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                inc,
  input  logic                                dec,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   count,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   count_next,
  output logic                                full
);

  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

  logic inc_eff;
  logic dec_eff;

  assign full = (count == CW'(MAX_INFLIGHT));

  // A retire with nothing outstanding cannot match any launch, so it is
  // dropped; an increment alongside it at zero still counts.
  always_comb begin
    inc_eff    = inc && !full;
    dec_eff    = dec && (count != '0);
    count_next = count;
    case ({inc_eff, dec_eff})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) count <= '0;
    else        count <= count_next;
  end

endmodule

// File: rtl/aes_key_ctrl.sv
// Key controller: accepts cipher keys, sequences the external key
// expansion engine, gates block launches into the cipher pipeline and
// drains outstanding blocks before a rekey.
//   clk, reset   : clock, synchronous active-low reset
//   bus          : key-write and block handshakes (slave side)
//   kexp_start   : one-cycle start pulse to the expansion engine
//   kexp_key     : latched key driven to the engine
//   kexp_valid   : engine reports all round keys valid
//   keys_ready   : round keys usable (READY state)
//   busy         : expanding or draining
//   err_timeout  : sticky expansion-timeout flag
//   in_flight    : outstanding block count
//   key_epoch    : completed expansions, wraps 15 -> 0
module aes_key_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  parameter int unsigned EXP_TIMEOUT  = DEF_EXP_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              reset,
  aes_key_ctrl_if.slave                     bus,
  output logic                              kexp_start,
  output logic [AES_KEY_W-1:0]              kexp_key,
  input  logic                              kexp_valid,
  output logic                              keys_ready,
  output logic                              busy,
  output logic                              err_timeout,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] in_flight,
  output logic [3:0]                        key_epoch
);

  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned TW = $clog2(EXP_TIMEOUT + 1);

  aes_key_ctrl_state_t state, next_state;
  logic                key_hs;
  logic                full;
  logic [CW-1:0]       cnt_next;
  logic [TW-1:0]       tmo_cnt;

  assign bus.key_wr_ready = reset && ((state == ST_IDLE) || (state == ST_READY) ||
                                      (state == ST_ERROR));
  assign key_hs           = bus.key_wr_valid && bus.key_wr_ready;
  // A key write in the same cycle wins over a launch request.
  assign bus.blk_grant    = (state == ST_READY) && bus.blk_req && !full && !key_hs;
  assign keys_ready       = (state == ST_READY);
  assign busy             = (state == ST_EXPAND) || (state == ST_DRAIN);

  aes_inflight_cnt #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_inflight (
    .clk        (clk),
    .reset      (reset),
    .inc        (bus.blk_grant),
    .dec        (bus.blk_done),
    .count      (in_flight),
    .count_next (cnt_next),
    .full       (full)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_ERROR: if (key_hs) next_state = ST_EXPAND;
      // kexp_valid may still be high from the previous key during the
      // start cycle, so it is only trusted from the following cycle.
      ST_EXPAND: if (!kexp_start) begin
        if (kexp_valid)                       next_state = ST_READY;
        else if (tmo_cnt == TW'(EXP_TIMEOUT)) next_state = ST_ERROR;
      end
      ST_READY: if (key_hs) next_state = (cnt_next != '0) ? ST_DRAIN : ST_EXPAND;
      ST_DRAIN: if (in_flight == '0) next_state = ST_EXPAND;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      kexp_start  <= 1'b0;
      kexp_key    <= '0;
      err_timeout <= 1'b0;
      key_epoch   <= '0;
      tmo_cnt     <= '0;
    end else begin
      state      <= next_state;
      kexp_start <= (next_state == ST_EXPAND) && (state != ST_EXPAND);
      tmo_cnt    <= ((state == ST_EXPAND) && (next_state == ST_EXPAND)) ?
                    tmo_cnt + TW'(1) : '0;
      if (key_hs) begin
        kexp_key    <= bus.key_wr_data;
        err_timeout <= 1'b0;
      end
      if ((state == ST_EXPAND) && (next_state == ST_ERROR)) err_timeout <= 1'b1;
      if ((state == ST_EXPAND) && (next_state == ST_READY)) key_epoch <= key_epoch + 4'd1;
    end
  end

endmodule

// File: tb/tb_aes_key_ctrl.sv
// Self-checking bench for aes_key_ctrl: directed key loads, pipeline
// fill, rekey with drain, expansion timeout, reset mid-expansion and
// epoch wrap, with a queue-based scoreboard for start pulses and
// keys_ready rises.
module tb_aes_key_ctrl;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         kexp_start;
  logic [127:0] kexp_key;
  logic         kexp_valid;
  logic         keys_ready;
  logic         busy;
  logic         err_timeout;
  logic [3:0]   in_flight;
  logic [3:0]   key_epoch;

  aes_key_ctrl_if bus();

  aes_key_ctrl #(.MAX_INFLIGHT(11), .EXP_TIMEOUT(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .kexp_start  (kexp_start),
    .kexp_key    (kexp_key),
    .kexp_valid  (kexp_valid),
    .keys_ready  (keys_ready),
    .busy        (busy),
    .err_timeout (err_timeout),
    .in_flight   (in_flight),
    .key_epoch   (key_epoch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int grant_cnt = 0;
  int eng_lat = 12;

  typedef struct { int cyc; logic [127:0] key; } start_exp_t;
  typedef struct { int cyc; logic [3:0] epoch; } rdy_exp_t;
  start_exp_t start_q[$];
  rdy_exp_t   rdy_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops scoreboard entries whenever the DUT shows a start pulse
  // or a keys_ready rise; also counts grants.
  initial begin
    logic       rdy_prev;
    start_exp_t se;
    rdy_exp_t   re;
    rdy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (kexp_start) begin
          if (start_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_start: got start at cycle %0d expected none", cyc);
          end else begin
            se = start_q.pop_front();
            chk("start_cycle", cyc, se.cyc);
            chk("start_key", kexp_key, se.key);
          end
        end
        if (keys_ready && !rdy_prev) begin
          if (rdy_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ready: got keys_ready at cycle %0d expected none", cyc);
          end else begin
            re = rdy_q.pop_front();
            chk("ready_cycle", cyc, re.cyc);
            chk("ready_epoch", key_epoch, re.epoch);
          end
        end
        if (bus.blk_grant) grant_cnt++;
      end
      rdy_prev = keys_ready;
    end
  end

  // Expansion engine model: raises kexp_valid eng_lat cycles after start,
  // drops it on the next start; eng_lat == 0 never completes.
  initial begin
    logic armed;
    int   st;
    armed = 1'b0; st = 0; kexp_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        armed = 1'b0; kexp_valid = 1'b0;
      end else if (kexp_start) begin
        armed = 1'b1; st = cyc; kexp_valid = 1'b0;
      end else if (armed && eng_lat > 0 && cyc == st + eng_lat) begin
        kexp_valid = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!keys_ready && n < 64) begin tick(1); n++; end
    chk("wait_ready", keys_ready, 1'b1);
  endtask

  // Offers a key for one cycle; sd = expected cycles to start pulse.
  task automatic send_key(input logic [127:0] k, input int sd, input bit push_rdy,
                          input logic [3:0] ep);
    int c = cyc;
    start_exp_t se;
    rdy_exp_t   re;
    chk("key_wr_ready", bus.key_wr_ready, 1'b1);
    se.cyc = c + sd; se.key = k;
    start_q.push_back(se);
    if (push_rdy) begin
      re.cyc = c + sd + 13; re.epoch = ep;
      rdy_q.push_back(re);
    end
    bus.key_wr_valid = 1'b1;
    bus.key_wr_data  = k;
    tick(1);
    bus.key_wr_valid = 1'b0;
  endtask

  initial begin
    int g, s;
    logic [127:0] k;
    reset = 1'b0;
    bus.key_wr_valid = 1'b0; bus.key_wr_data = '0;
    bus.blk_req = 1'b0; bus.blk_done = 1'b0;
    tick(3);
    chk("rst_wr_ready", bus.key_wr_ready, 1'b0);
    chk("rst_kexp_key", kexp_key, 128'h0);
    chk("rst_keys_ready", keys_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_in_flight", in_flight, 4'd0);
    chk("rst_epoch", key_epoch, 4'd0);
    reset = 1'b1;
    #1;
    chk("rel_wr_ready", bus.key_wr_ready, 1'b1);

    // Basic key load
    send_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1, 1'b1, 4'd1);
    chk("expand_busy", busy, 1'b1);
    chk("expand_wr_ready", bus.key_wr_ready, 1'b0);
    wait_ready();
    chk("epoch_1", key_epoch, 4'd1);

    // Fill pipeline: 15 request cycles, only 11 grants
    g = grant_cnt;
    bus.blk_req = 1'b1;
    tick(15);
    chk("grant_when_full", bus.blk_grant, 1'b0);
    bus.blk_req = 1'b0;
    chk("grant_count", grant_cnt - g, 11);
    chk("in_flight_full", in_flight, 4'd11);

    // Retire one, then grant and retire together
    bus.blk_done = 1'b1; tick(1); bus.blk_done = 1'b0;
    chk("in_flight_10", in_flight, 4'd10);
    g = grant_cnt;
    bus.blk_req = 1'b1; bus.blk_done = 1'b1; tick(1);
    bus.blk_req = 1'b0; bus.blk_done = 1'b0;
    chk("simul_grant", grant_cnt - g, 1);
    chk("simul_in_flight", in_flight, 4'd10);
    bus.blk_done = 1'b1; tick(7); bus.blk_done = 1'b0;
    chk("in_flight_3", in_flight, 4'd3);

    // Rekey with drain, blk_req held through the handshake cycle
    g = grant_cnt;
    bus.blk_req = 1'b1;
    send_key(128'h000102030405060708090a0b0c0d0e0f, 8, 1'b1, 4'd2);
    chk("drain_keys_ready", keys_ready, 1'b0);
    chk("drain_busy", busy, 1'b1);
    chk("drain_wr_ready", bus.key_wr_ready, 1'b0);
    tick(1);
    for (int i = 0; i < 3; i++) begin
      bus.blk_done = 1'b1; tick(1); bus.blk_done = 1'b0; tick(1);
    end
    bus.blk_req = 1'b0;
    chk("drain_no_grant", grant_cnt - g, 0);
    chk("drain_in_flight", in_flight, 4'd0);
    bus.blk_done = 1'b1; tick(1); bus.blk_done = 1'b0;
    chk("done_at_zero", in_flight, 4'd0);
    wait_ready();

    // Timeout: engine never completes
    eng_lat = 0;
    send_key(128'hffeeddccbbaa99887766554433221100, 1, 1'b0, 4'd0);
    s = cyc;
    wait_cyc(s + 31);
    chk("tmo_err_early", err_timeout, 1'b0);
    wait_cyc(s + 33);
    chk("tmo_err", err_timeout, 1'b1);
    chk("tmo_keys_ready", keys_ready, 1'b0);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_epoch", key_epoch, 4'd2);
    eng_lat = 12;
    send_key(128'h3243f6a8885a308d313198a2e0370734, 1, 1'b1, 4'd3);
    chk("tmo_err_cleared", err_timeout, 1'b0);
    wait_ready();

    // Reset in the fifth cycle of expansion
    send_key(128'h0123456789abcdeffedcba9876543210, 1, 1'b0, 4'd0);
    s = cyc;
    wait_cyc(s + 5);
    reset = 1'b0;
    tick(1);
    chk("mid_rst_start", kexp_start, 1'b0);
    chk("mid_rst_key", kexp_key, 128'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_keys_ready", keys_ready, 1'b0);
    chk("mid_rst_epoch", key_epoch, 4'd0);
    chk("mid_rst_wr_ready", bus.key_wr_ready, 1'b0);
    tick(1);
    reset = 1'b1;
    #1;
    chk("mid_rel_wr_ready", bus.key_wr_ready, 1'b1);
    tick(20);
    chk("mid_rst_no_ready", keys_ready, 1'b0);

    // Sixteen expansions wrap the epoch
    for (int i = 0; i < 16; i++) begin
      k = {4{32'hc0ffee00 + 32'(i)}};
      send_key(k, 1, 1'b1, 4'(i + 1));
      wait_ready();
    end
    chk("epoch_wrap", key_epoch, 4'd0);

    tick(5);
    chk("start_q_empty", start_q.size(), 0);
    chk("rdy_q_empty", rdy_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no completion by cycle %0d expected finish", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
